// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and period lengths for the LED pattern generator.
package led_pattern_pkg;

    localparam logic [1:0] MODE_FILL_DRAIN = 2'd0;
    localparam logic [1:0] MODE_CHASE      = 2'd1;
    localparam logic [1:0] MODE_BOUNCE     = 2'd2;
    localparam logic [1:0] MODE_BLINK      = 2'd3;

    // Final step index of each mode's period for an n-LED bus.
    function automatic int unsigned last_step(input logic [1:0] mode, input int unsigned n);
        int unsigned r;
        case (mode)
            MODE_FILL_DRAIN: r = 2 * n - 1;
            MODE_CHASE:      r = n - 1;
            MODE_BOUNCE:     r = 2 * n - 3;
            default:         r = 1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Prescaler: pulses tick on every DIV-th enabled cycle; clr restarts the count.
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_nodiv
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset};
            assign tick     = en & ~clr;
        end else begin : g_div
            localparam int unsigned PW = $clog2(DIV);
            logic [PW-1:0] r_p;

            assign tick = en & ~clr & (r_p == PW'(DIV - 1));

            // Count freezes while en is low so a step always spans DIV enabled cycles.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_p <= '0;
                end else if (clr || tick) begin
                    r_p <= '0;
                end else if (en) begin
                    r_p <= r_p + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: fill/drain, chase, bounce and blink on an N-bit bus.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] out,
    output logic         wrap
);

    localparam int unsigned KW = $clog2(2 * N);

    logic [1:0]    r_mode_q;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_out;
    logic          r_wrap;

    logic          w_restart;
    logic          w_tick;
    logic          w_at_last;
    logic [KW-1:0] w_last;
    logic [KW-1:0] w_k_next;

    // LED image for step k of mode m; shifts are N bits wide and drop overflow.
    function automatic logic [N-1:0] f_pattern(input logic [1:0] m, input logic [KW-1:0] k);
        logic [N-1:0] ones;
        logic [N-1:0] one;
        int unsigned  ki;
        ones = '1;
        one  = N'(1);
        ki   = 32'(k);
        case (m)
            MODE_FILL_DRAIN: begin
                if (ki == 0)      f_pattern = '0;
                else if (ki <= N) f_pattern = ones >> (N - ki);
                else              f_pattern = ones << (ki - N);
            end
            MODE_CHASE:  f_pattern = one << ki;
            MODE_BOUNCE: f_pattern = (ki < N) ? (one << ki) : (one << (2 * N - 2 - ki));
            default:     f_pattern = (ki == 0) ? '0 : ones;
        endcase
    endfunction

    assign w_restart = (mode != r_mode_q);
    assign w_last    = KW'(last_step(r_mode_q, N));
    assign w_at_last = (r_k == w_last);
    assign w_k_next  = w_at_last ? '0 : r_k + KW'(1);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (w_restart),
        .tick  (w_tick)
    );

    // A mode change overrides any tick and restarts the new pattern at step 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_q <= MODE_FILL_DRAIN;
            r_k      <= '0;
            r_out    <= '0;
            r_wrap   <= 1'b0;
        end else if (w_restart) begin
            r_mode_q <= mode;
            r_k      <= '0;
            r_out    <= f_pattern(mode, KW'(0));
            r_wrap   <= 1'b0;
        end else if (w_tick) begin
            r_k      <= w_k_next;
            r_out    <= f_pattern(r_mode_q, w_k_next);
            r_wrap   <= w_at_last;
        end else begin
            r_wrap   <= 1'b0;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;

endmodule
